// File: rtl/pixel_assembler.sv
// pixel_assembler
//   Packs the post-header payload byte stream (R, G, B order) into 24-bit
//   RGB pixels. Each pixel carries its 0-based column/row coordinate, and the
//   last pixel of the frame raises frame_done.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   reset        asynchronous, active-high, clears all state
//   byte_in      payload byte from the header parser
//   byte_valid   byte_in holds a new payload byte this cycle
//   height       frame height in rows (latched on the first byte)
//   width        frame width in columns (latched on the first byte)
//   pixel        assembled pixel {R,G,B}, R in [23:16]
//   pixel_valid  one-cycle pulse, pixel/x/y valid
//   x, y         column / row of the current pixel
//   frame_done   level, high from the last pixel onwards
//   dim_error    level, width or height was 0 at frame start
//   overrun      sticky, a byte arrived after frame_done
module pixel_assembler #(
  parameter int DIM_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  input  logic [DIM_W-1:0] height,
  input  logic [DIM_W-1:0] width,
  output logic [23:0]      pixel,
  output logic             pixel_valid,
  output logic [DIM_W-1:0] x,
  output logic [DIM_W-1:0] y,
  output logic             frame_done,
  output logic             dim_error,
  output logic             overrun
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ASSEMBLE = 2'd1;
  localparam logic [1:0] ST_DONE     = 2'd2;
  localparam logic [1:0] ST_ERROR    = 2'd3;

  localparam logic [DIM_W-1:0] DIM_ZERO = '0;
  localparam logic [DIM_W-1:0] DIM_ONE  = {{(DIM_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [DIM_W-1:0] col_q, col_d;
  logic [DIM_W-1:0] row_q, row_d;
  logic [DIM_W-1:0] w_q, w_d;
  logic [DIM_W-1:0] h_q, h_d;
  logic [7:0]       r_q, r_d;
  logic [7:0]       g_q, g_d;
  logic [23:0]      pixel_q, pixel_d;
  logic             pv_q, pv_d;
  logic [DIM_W-1:0] x_q, x_d;
  logic [DIM_W-1:0] y_q, y_d;
  logic             fd_q, fd_d;
  logic             de_q, de_d;
  logic             ov_q, ov_d;

  logic last_col;
  logic last_row;

  // End-of-row / end-of-frame come from comparing the running counters with
  // the latched dimensions, so no width*height product is ever formed.
  assign last_col = (col_q == (w_q - DIM_ONE));
  assign last_row = (row_q == (h_q - DIM_ONE));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    col_d   = col_q;
    row_d   = row_q;
    w_d     = w_q;
    h_d     = h_q;
    r_d     = r_q;
    g_d     = g_q;
    pixel_d = pixel_q;
    pv_d    = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    fd_d    = fd_q;
    de_d    = de_q;
    ov_d    = ov_q;

    case (state_q)
      ST_IDLE: begin
        if (byte_valid) begin
          // Dimensions are frozen for the whole frame from the first byte.
          w_d = width;
          h_d = height;
          if ((width == DIM_ZERO) || (height == DIM_ZERO)) begin
            state_d = ST_ERROR;
            de_d    = 1'b1;
          end else begin
            r_d     = byte_in;
            idx_d   = 2'd1;
            state_d = ST_ASSEMBLE;
          end
        end
      end

      ST_ASSEMBLE: begin
        if (byte_valid) begin
          case (idx_q)
            2'd0: begin
              r_d   = byte_in;
              idx_d = 2'd1;
            end
            2'd1: begin
              g_d   = byte_in;
              idx_d = 2'd2;
            end
            default: begin
              pixel_d = {r_q, g_q, byte_in};
              pv_d    = 1'b1;
              x_d     = col_q;
              y_d     = row_q;
              idx_d   = 2'd0;
              if (last_col) begin
                col_d = DIM_ZERO;
                if (last_row) begin
                  // frame_done registers alongside the final pixel_valid.
                  fd_d    = 1'b1;
                  state_d = ST_DONE;
                end else begin
                  row_d = row_q + DIM_ONE;
                end
              end else begin
                col_d = col_q + DIM_ONE;
              end
            end
          endcase
        end
      end

      ST_DONE: begin
        if (byte_valid) begin
          ov_d = 1'b1;
        end
      end

      default: begin
        // ST_ERROR: every byte is dropped until reset.
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      col_q   <= DIM_ZERO;
      row_q   <= DIM_ZERO;
      w_q     <= DIM_ZERO;
      h_q     <= DIM_ZERO;
      r_q     <= 8'd0;
      g_q     <= 8'd0;
      pixel_q <= 24'd0;
      pv_q    <= 1'b0;
      x_q     <= DIM_ZERO;
      y_q     <= DIM_ZERO;
      fd_q    <= 1'b0;
      de_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      col_q   <= col_d;
      row_q   <= row_d;
      w_q     <= w_d;
      h_q     <= h_d;
      r_q     <= r_d;
      g_q     <= g_d;
      pixel_q <= pixel_d;
      pv_q    <= pv_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fd_q    <= fd_d;
      de_q    <= de_d;
      ov_q    <= ov_d;
    end
  end

  assign pixel       = pixel_q;
  assign pixel_valid = pv_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_done  = fd_q;
  assign dim_error   = de_q;
  assign overrun     = ov_q;

endmodule
